// File: rtl/xadc_drp_responder.sv
// XADC DRP responder: a cycle-accurate stand-in for the XADC primitive.
// It holds the 128x16 DRP register space and answers DEN/DWE transactions
// with a DRDY handshake. It also runs a continuous auxiliary-channel
// sequencer that drives MUXADDR/BUSY/EOS and loads VAUX status registers
// 0x10-0x13 from the aux_value stimulus bus.
//
// Sequencer states
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | BUSY=0; re-evaluate mode (0x41[15:12]) and enables (0x49[3:0])
//   S_CONVERT | BUSY=1 for CONV_CYCLES cycles on channel r_ch
//   S_UPDATE  | one cycle; write 0x10+ch, EOS if ch is the last enabled channel
//
// RD_LATENCY must lie in 1..15 and CONV_CYCLES must be at least 2.
module xadc_drp_responder #(
  parameter int RD_LATENCY  = 4,
  parameter int CONV_CYCLES = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic        EOS,
  output logic [4:0]  MUXADDR,
  input  logic [47:0] aux_value,
  output logic        drp_err
);

  localparam int CC_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } seq_state_t;

  // register space
  logic [15:0] r_mem [0:127];

  // DRP transaction state
  logic        r_pend;
  logic [3:0]  r_cnt;
  logic        r_is_rd;
  logic [15:0] r_rdata;
  logic [15:0] r_do;
  logic        r_drdy;
  logic        r_err;

  // sequencer state
  seq_state_t  r_state;
  logic [1:0]  r_ch;
  logic [1:0]  r_next_idx;
  logic [CC_W-1:0] r_cc;
  logic        r_busy;
  logic        r_eos;
  logic [4:0]  r_mux;

  // combinational helpers
  logic        w_drp_accept;
  logic        w_drp_wr;
  logic [3:0]  w_mode;
  logic [3:0]  w_en;
  logic [1:0]  w_sel_ch;
  logic        w_sel_found;
  logic        w_has_above;
  logic [11:0] w_aux_ch;

  assign w_drp_accept = DEN && !r_pend;
  // only the upper half of the address space is writable
  assign w_drp_wr     = w_drp_accept && DWE && DADDR[6];
  assign w_mode       = r_mem[7'h41][15:12];
  assign w_en         = r_mem[7'h49][3:0];

  // Channel selection: lowest enabled channel at or above the next index.
  // If a config change left nothing enabled at or above it, wrap to the
  // lowest enabled channel so the sequence keeps going.
  always_comb begin
    w_sel_ch    = 2'd0;
    w_sel_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (w_en[i] && (2'(i) >= r_next_idx)) begin
        w_sel_ch    = 2'(i);
        w_sel_found = 1'b1;
      end
    end
    if (!w_sel_found) begin
      for (int i = 3; i >= 0; i--) begin
        if (w_en[i]) begin
          w_sel_ch = 2'(i);
        end
      end
    end
  end

  // The current channel is the last of the sequence when no enabled channel lies above it.
  always_comb begin
    w_has_above = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (w_en[i] && (2'(i) > r_ch)) begin
        w_has_above = 1'b1;
      end
    end
  end

  // Select the 12-bit stimulus sample for the channel being converted.
  always_comb begin
    w_aux_ch = aux_value[11:0];
    case (r_ch)
      2'd0:    w_aux_ch = aux_value[11:0];
      2'd1:    w_aux_ch = aux_value[23:12];
      2'd2:    w_aux_ch = aux_value[35:24];
      default: w_aux_ch = aux_value[47:36];
    endcase
  end

  // Register file: defaults on reset, DRP writes and sequencer status updates.
  // DRP writes only reach 0x40-0x7F and the sequencer only 0x10-0x13, so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        r_mem[i] <= 16'h0000;
      end
      r_mem[7'h40] <= 16'hB903;
      r_mem[7'h41] <= 16'h20F0;
      r_mem[7'h42] <= 16'h3F00;
      r_mem[7'h49] <= 16'h000F;
      r_mem[7'h4B] <= 16'h000F;
      r_mem[7'h4F] <= 16'h000F;
    end else begin
      if (w_drp_wr) begin
        r_mem[DADDR] <= DI;
      end
      if (r_state == S_UPDATE) begin
        r_mem[{5'b00100, r_ch}] <= {w_aux_ch, 4'h0};
      end
    end
  end

  // DRP handshake: capture on DEN, count down to DRDY, reject overlapping DEN.
  // The read value is latched at the DEN edge so a same-edge sequencer update is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_cnt   <= 4'd0;
      r_is_rd <= 1'b0;
      r_rdata <= 16'h0000;
      r_do    <= 16'h0000;
      r_drdy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= DEN && r_pend;
      if (!r_pend) begin
        r_drdy <= 1'b0;
        if (DEN) begin
          r_pend  <= 1'b1;
          r_is_rd <= !DWE;
          r_rdata <= r_mem[DADDR];
          r_cnt   <= 4'(RD_LATENCY - 1);
          // Latency 1: DRDY lands in the cycle right after DEN, so skip the countdown.
          if (RD_LATENCY == 1) begin
            r_drdy <= 1'b1;
            if (!DWE) begin
              r_do <= r_mem[DADDR];
            end
          end
        end
      end else if (r_drdy) begin
        // DRDY cycle is still pending; the slot frees only after it.
        r_pend <= 1'b0;
        r_drdy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_drdy <= 1'b1;
          if (r_is_rd) begin
            r_do <= r_rdata;
          end
        end
      end
    end
  end

  // Aux-channel sequencer with registered BUSY, EOS and MUXADDR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ch       <= 2'd0;
      r_next_idx <= 2'd0;
      r_cc       <= '0;
      r_busy     <= 1'b0;
      r_eos      <= 1'b0;
      r_mux      <= 5'h10;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_eos <= 1'b0;
          if ((w_mode == 4'h2) && (w_en != 4'h0)) begin
            r_state <= S_CONVERT;
            r_ch    <= w_sel_ch;
            r_mux   <= {3'b100, w_sel_ch};
            r_busy  <= 1'b1;
            r_cc    <= CC_W'(CONV_CYCLES - 1);
          end
        end
        S_CONVERT: begin
          if (r_cc == '0) begin
            r_state    <= S_UPDATE;
            r_busy     <= 1'b0;
            r_eos      <= !w_has_above;
            r_next_idx <= w_has_above ? (r_ch + 2'd1) : 2'd0;
          end else begin
            r_cc <= r_cc - CC_W'(1);
          end
        end
        S_UPDATE: begin
          r_eos   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_eos   <= 1'b0;
        end
      endcase
    end
  end

  assign DO      = r_do;
  assign DRDY    = r_drdy;
  assign drp_err = r_err;
  assign BUSY    = r_busy;
  assign EOS     = r_eos;
  assign MUXADDR = r_mux;

endmodule
